// File: rtl/cmd_sched.sv
// Round-robin scheduler for two command requesters sharing one strobed command bus.
// Ack is combinational in IDLE; cmd_vld runs CMD_LEN cycles, then waits for cmd_done (bounded), then a gap.
module cmd_sched #(
  parameter int CMD_LEN = 10,
  parameter int GAP_LEN = 16,
  parameter int TMO_LEN = 1023
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic       reqa_vld,
  input  logic [7:0] reqa_dev,
  input  logic [7:0] reqa_mod,
  input  logic [7:0] reqa_addr,
  input  logic [7:0] reqa_data,
  output logic       reqa_ack,
  input  logic       reqb_vld,
  input  logic [7:0] reqb_dev,
  input  logic [7:0] reqb_mod,
  input  logic [7:0] reqb_addr,
  input  logic [7:0] reqb_data,
  output logic       reqb_ack,
  output logic [7:0] dev_id,
  output logic [7:0] mod_id,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       cmd_vld,
  input  logic       cmd_done,
  output logic       busy,
  output logic       grant_b,
  output logic       tmo_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] md;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  localparam logic [15:0] CMD_LAST = 16'(CMD_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);
  localparam logic [15:0] TMO_LAST = 16'(TMO_LEN - 1);
  localparam bit          GAP_SKIP = (GAP_LEN == 0);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_seen_q, done_seen_d;
  logic        last_b_q, last_b_d;
  logic        grant_b_q, grant_b_d;
  logic        tmo_err_q, tmo_err_d;
  cmd_t        cmd_q, cmd_d;

  cmd_t        req_a, req_b;
  logic        grant_go;
  logic        pick_b;
  logic        wait_exit;

  assign req_a = {reqa_dev, reqa_mod, reqa_addr, reqa_data};
  assign req_b = {reqb_dev, reqb_mod, reqb_addr, reqb_data};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_seen_d = done_seen_q;
    last_b_d    = last_b_q;
    grant_b_d   = grant_b_q;
    cmd_d       = cmd_q;
    tmo_err_d   = 1'b0;
    grant_go    = 1'b0;
    pick_b      = 1'b0;
    wait_exit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // No grant while reset is held, so no ack can leak during reset cycles.
        if ((reqa_vld || reqb_vld) && !rst_sys) begin
          grant_go    = 1'b1;
          pick_b      = reqb_vld && (!reqa_vld || !last_b_q);
          cmd_d       = pick_b ? req_b : req_a;
          grant_b_d   = pick_b;
          last_b_d    = pick_b;
          cnt_d       = 16'd0;
          done_seen_d = 1'b0;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (cmd_done) begin
          done_seen_d = 1'b1;
        end
        if (cnt_q == CMD_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_WAIT: begin
        wait_exit = cmd_done || done_seen_q || (cnt_q == TMO_LAST);
        if (wait_exit) begin
          tmo_err_d   = !(cmd_done || done_seen_q);
          done_seen_d = 1'b0;
          cnt_d       = 16'd0;
          state_d     = GAP_SKIP ? S_IDLE : S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      done_seen_q <= 1'b0;
      last_b_q    <= 1'b1;
      grant_b_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      cmd_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_seen_q <= done_seen_d;
      last_b_q    <= last_b_d;
      grant_b_q   <= grant_b_d;
      tmo_err_q   <= tmo_err_d;
      cmd_q       <= cmd_d;
    end
  end

  assign reqa_ack = grant_go && !pick_b;
  assign reqb_ack = grant_go && pick_b;
  assign cmd_vld  = (state_q == S_ISSUE);
  assign busy     = (state_q != S_IDLE);
  assign grant_b  = grant_b_q;
  assign tmo_err  = tmo_err_q;
  assign dev_id   = cmd_q.dev;
  assign mod_id   = cmd_q.md;
  assign cmd_addr = cmd_q.addr;
  assign cmd_data = cmd_q.data;

endmodule

// File: tb/tb_cmd_sched.sv
// Bench for cmd_sched: directed scenarios plus a randomized run against a timestamp-based reference model.
module tb_cmd_sched;

  localparam int CMD_LEN = 10;
  localparam int GAP_LEN = 16;
  localparam int TMO_LEN = 1023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, a_vld, b_vld, done;
  logic [7:0] a_dev, a_mod, a_addr, a_data, b_dev, b_mod, b_addr, b_data;
  logic       a_ack, b_ack, vld, busy, gb, tmo;
  logic [7:0] dev_o, mod_o, addr_o, data_o;
  logic [31:0] bus;
  assign bus = {dev_o, mod_o, addr_o, data_o};

  logic       rst2, a2_vld, b2_vld, done2;
  logic [7:0] a2_dev, a2_mod, a2_addr, a2_data, b2_dev, b2_mod, b2_addr, b2_data;
  logic       a2_ack, b2_ack, vld2, busy2, gb2, tmo2;
  logic [7:0] dev2_o, mod2_o, addr2_o, data2_o;

  int n_run = 0;
  int n_fail = 0;

  cmd_sched #(.CMD_LEN(CMD_LEN), .GAP_LEN(GAP_LEN), .TMO_LEN(TMO_LEN)) dut (
    .clk_sys(clk), .rst_sys(rst),
    .reqa_vld(a_vld), .reqa_dev(a_dev), .reqa_mod(a_mod), .reqa_addr(a_addr), .reqa_data(a_data), .reqa_ack(a_ack),
    .reqb_vld(b_vld), .reqb_dev(b_dev), .reqb_mod(b_mod), .reqb_addr(b_addr), .reqb_data(b_data), .reqb_ack(b_ack),
    .dev_id(dev_o), .mod_id(mod_o), .cmd_addr(addr_o), .cmd_data(data_o),
    .cmd_vld(vld), .cmd_done(done), .busy(busy), .grant_b(gb), .tmo_err(tmo)
  );

  cmd_sched #(.CMD_LEN(1), .GAP_LEN(0), .TMO_LEN(8)) dut2 (
    .clk_sys(clk), .rst_sys(rst2),
    .reqa_vld(a2_vld), .reqa_dev(a2_dev), .reqa_mod(a2_mod), .reqa_addr(a2_addr), .reqa_data(a2_data), .reqa_ack(a2_ack),
    .reqb_vld(b2_vld), .reqb_dev(b2_dev), .reqb_mod(b2_mod), .reqb_addr(b2_addr), .reqb_data(b2_data), .reqb_ack(b2_ack),
    .dev_id(dev2_o), .mod_id(mod2_o), .cmd_addr(addr2_o), .cmd_data(data2_o),
    .cmd_vld(vld2), .cmd_done(done2), .busy(busy2), .grant_b(gb2), .tmo_err(tmo2)
  );

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; a_vld = 1'b1; b_vld = 1'b1; done = 1'b0;
    {a_dev, a_mod, a_addr, a_data} = 32'hA1A2A3A4;
    {b_dev, b_mod, b_addr, b_data} = 32'hB1B2B3B4;
    adv(); adv();
    smp();
    n_run++; if (vld !== 1'b0)  begin n_fail++; $display("FAIL reset_cmd_vld got=%b want=0", vld); end
    n_run++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack_a got=%b want=0", a_ack); end
    n_run++; if (b_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack_b got=%b want=0", b_ack); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_run++; if (tmo !== 1'b0)  begin n_fail++; $display("FAIL reset_tmo got=%b want=0", tmo); end
    n_run++; if (gb !== 1'b0)   begin n_fail++; $display("FAIL reset_grant_b got=%b want=0", gb); end
    n_run++; if (bus !== 32'h0) begin n_fail++; $display("FAIL reset_fields got=%h want=00000000", bus); end
    adv();
    rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
  endtask

  task automatic test_single_a();
    int nv, bad, ga;
    a_vld = 1'b1; {a_dev, a_mod, a_addr, a_data} = 32'h00123456;
    smp();
    n_run++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_a got=%b want=1", a_ack); end
    n_run++; if (b_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_b got=%b want=0", b_ack); end
    adv();
    a_vld = 1'b0;
    nv = 0; bad = 0; ga = 0;
    for (int i = 0; i < CMD_LEN; i++) begin
      smp();
      nv += int'(vld);
      ga += int'(a_ack);
      if (bus !== 32'h00123456) bad++;
      adv();
    end
    n_run++; if (nv != 10) begin n_fail++; $display("FAIL single_vld_len got=%0d want=10", nv); end
    n_run++; if (bad != 0) begin n_fail++; $display("FAIL single_fields bad_cycles=%0d want=0", bad); end
    n_run++; if (ga != 0)  begin n_fail++; $display("FAIL single_ack_len extra_acks=%0d want=0", ga); end
    smp();
    n_run++; if (vld !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_wait_entry vld=%b busy=%b want vld=0 busy=1", vld, busy); end
    repeat (5) adv();
    done = 1'b1;
    smp();
    adv();
    done = 1'b0;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      smp();
      nv += int'(busy);
      adv();
    end
    n_run++; if (nv != 16) begin n_fail++; $display("FAIL single_gap_busy got=%0d want=16", nv); end
    smp();
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall got=%b want=0", busy); end
    n_run++; if (bus !== 32'h00123456) begin n_fail++; $display("FAIL single_fields_hold got=%h want=00123456", bus); end
    adv();
  endtask

  task automatic test_round_robin();
    int seq[4];
    int tk[4];
    int n, both;
    logic prev;
    rst = 1'b1; adv(); rst = 1'b0;
    a_vld = 1'b1; b_vld = 1'b1;
    {a_dev, a_mod, a_addr, a_data} = 32'h0A0B0C0D;
    {b_dev, b_mod, b_addr, b_data} = 32'h1A1B1C1D;
    n = 0; both = 0; prev = 1'b0;
    for (int t = 0; t < 200 && n < 4; t++) begin
      done = prev && !vld;
      smp();
      if (a_ack && b_ack) both++;
      if (a_ack || b_ack) begin
        seq[n] = int'(b_ack);
        tk[n] = t;
        n++;
      end
      prev = vld;
      adv();
    end
    done = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    n_run++; if (n != 4) begin n_fail++; $display("FAIL rr_grant_count got=%0d want=4", n); end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        n_run++; if (seq[i] != (i % 2)) begin n_fail++; $display("FAIL rr_order idx=%0d got_b=%0d want_b=%0d", i, seq[i], i % 2); end
      end
    end
    for (int i = 1; i < 4; i++) begin
      if (i < n) begin
        n_run++; if (tk[i] - tk[i-1] != 28) begin n_fail++; $display("FAIL rr_period idx=%0d got=%0d want=28", i, tk[i] - tk[i-1]); end
      end
    end
    n_run++; if (both != 0) begin n_fail++; $display("FAIL rr_dual_ack got=%0d want=0", both); end
    rst = 1'b1; adv(); rst = 1'b0;
  endtask

  task automatic test_done_in_issue();
    int nt;
    a_vld = 1'b1; {a_dev, a_mod, a_addr, a_data} = 32'h03456789;
    smp();
    n_run++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL dii_ack got=%b want=1", a_ack); end
    adv();
    a_vld = 1'b0;
    repeat (3) adv();
    done = 1'b1;
    adv();
    done = 1'b0;
    repeat (6) adv();
    nt = 0;
    for (int i = 0; i < 18; i++) begin
      smp();
      nt += int'(tmo);
      if (i == 0) begin
        n_run++; if (vld !== 1'b0) begin n_fail++; $display("FAIL dii_wait_entry vld got=%b want=0", vld); end
      end
      if (i == 16) begin
        n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dii_gap_busy got=%b want=1", busy); end
      end
      if (i == 17) begin
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dii_idle got=%b want=0", busy); end
      end
      adv();
    end
    n_run++; if (nt != 0) begin n_fail++; $display("FAIL dii_no_tmo got=%0d want=0", nt); end
  endtask

  task automatic test_timeout();
    int k, nt;
    a_vld = 1'b1; {a_dev, a_mod, a_addr, a_data} = 32'h01914702;
    smp();
    n_run++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL tmo_ack got=%b want=1", a_ack); end
    adv();
    a_vld = 1'b0;
    repeat (CMD_LEN) adv();
    k = -1; nt = 0;
    for (int i = 0; i < 1041; i++) begin
      smp();
      if (tmo) begin
        nt++;
        if (k < 0) k = i;
      end
      if (i == 1023) begin
        n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_gap_busy got=%b want=1", busy); end
      end
      if (i == 1039) begin
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle got=%b want=0", busy); end
      end
      adv();
    end
    n_run++; if (k != 1023) begin n_fail++; $display("FAIL tmo_time got=%0d want=1023", k); end
    n_run++; if (nt != 1) begin n_fail++; $display("FAIL tmo_pulse_len got=%0d want=1", nt); end
    b_vld = 1'b1; {b_dev, b_mod, b_addr, b_data} = 32'h5A6B7C8D;
    smp();
    n_run++; if (b_ack !== 1'b1) begin n_fail++; $display("FAIL tmo_next_ack got=%b want=1", b_ack); end
    adv();
    b_vld = 1'b0;
    smp();
    n_run++; if (vld !== 1'b1 || gb !== 1'b1 || bus !== 32'h5A6B7C8D) begin
      n_fail++; $display("FAIL tmo_next_cmd vld=%b gb=%b bus=%h want 1 1 5a6b7c8d", vld, gb, bus);
    end
    adv();
    rst = 1'b1; adv(); rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nb;
    a_vld = 1'b1; {a_dev, a_mod, a_addr, a_data} = 32'h02917890;
    smp();
    n_run++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack got=%b want=1", a_ack); end
    adv();
    a_vld = 1'b0;
    adv();
    done = 1'b1;
    adv();
    done = 1'b0;
    adv();
    rst = 1'b1; a_vld = 1'b1; b_vld = 1'b1;
    {a_dev, a_mod, a_addr, a_data} = 32'h0A0B0C0D;
    {b_dev, b_mod, b_addr, b_data} = 32'h1A1B1C1D;
    adv();
    rst = 1'b0;
    smp();
    n_run++; if (vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld got=%b want=0", vld); end
    n_run++; if (bus !== 32'h0) begin n_fail++; $display("FAIL rstmid_fields got=%h want=00000000", bus); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    n_run++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_tie a=%b b=%b want a=1 b=0", a_ack, b_ack); end
    adv();
    a_vld = 1'b0;
    smp();
    n_run++; if (bus !== 32'h0A0B0C0D) begin n_fail++; $display("FAIL rstmid_new_fields got=%h want=0a0b0c0d", bus); end
    repeat (CMD_LEN) adv();
    nb = 0;
    for (int i = 0; i < 18; i++) begin
      smp();
      nb += int'(b_ack);
      if (i == 17) begin
        n_run++; if (busy !== 1'b1 || vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait_held busy=%b vld=%b want 1 0", busy, vld); end
      end
      adv();
    end
    n_run++; if (nb != 0) begin n_fail++; $display("FAIL rstmid_b_early got=%0d want=0", nb); end
    rst = 1'b1; b_vld = 1'b0; adv(); rst = 1'b0;
  endtask

  task automatic test_param();
    int tk[4];
    int seq[4];
    int n, both, multi, k;
    logic prev;
    rst2 = 1'b1; adv(); rst2 = 1'b0;
    a2_vld = 1'b1; b2_vld = 1'b1;
    n = 0; both = 0; multi = 0; prev = 1'b0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      done2 = prev && !vld2;
      smp();
      if (a2_ack && b2_ack) both++;
      if (vld2 && prev) multi++;
      if (a2_ack || b2_ack) begin
        tk[n] = t;
        seq[n] = int'(b2_ack);
        n++;
      end
      prev = vld2;
      adv();
    end
    done2 = 1'b0; a2_vld = 1'b0; b2_vld = 1'b0;
    n_run++; if (n != 4) begin n_fail++; $display("FAIL p_grant_count got=%0d want=4", n); end
    for (int i = 1; i < 4; i++) begin
      if (i < n) begin
        n_run++; if (tk[i] - tk[i-1] != 3) begin n_fail++; $display("FAIL p_period idx=%0d got=%0d want=3", i, tk[i] - tk[i-1]); end
        n_run++; if (seq[i] == seq[i-1]) begin n_fail++; $display("FAIL p_alternate idx=%0d got_b=%0d want_b=%0d", i, seq[i], 1 - seq[i-1]); end
      end
    end
    n_run++; if (multi != 0) begin n_fail++; $display("FAIL p_vld_pulse extra_cycles=%0d want=0", multi); end
    n_run++; if (both != 0) begin n_fail++; $display("FAIL p_dual_ack got=%0d want=0", both); end
    rst2 = 1'b1; adv(); rst2 = 1'b0;
    a2_vld = 1'b1;
    smp();
    adv();
    a2_vld = 1'b0;
    adv();
    k = -1;
    for (int i = 0; i < 12; i++) begin
      smp();
      if (tmo2 && k < 0) k = i;
      if (i == 7) begin
        n_run++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL p_wait_busy got=%b want=1", busy2); end
      end
      if (i == 8) begin
        n_run++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL p_tmo_idle got=%b want=0", busy2); end
      end
      adv();
    end
    n_run++; if (k != 8) begin n_fail++; $display("FAIL p_tmo_time got=%0d want=8", k); end
  endtask

  task automatic test_random();
    int m_busy, m_ack, m_wend, m_rec, m_lastb, m_gb, m_tmo_at, ws;
    logic [31:0] m_bus, fa, fb;
    logic e_aack, e_back, e_vld, e_busy, e_tmo, pb;
    rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0; done = 1'b0;
    adv();
    rst = 1'b0;
    m_busy = 0; m_ack = 0; m_wend = -1; m_rec = 0; m_lastb = 1; m_gb = 0; m_tmo_at = -1; m_bus = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (!a_vld && $urandom_range(0, 2) == 0) begin a_vld = 1'b1; {a_dev, a_mod, a_addr, a_data} = $urandom; end
      if (!b_vld && $urandom_range(0, 2) == 0) begin b_vld = 1'b1; {b_dev, b_mod, b_addr, b_data} = $urandom; end
      done = ($urandom_range(0, 5) == 0);
      smp();
      fa = {a_dev, a_mod, a_addr, a_data};
      fb = {b_dev, b_mod, b_addr, b_data};
      e_aack = 1'b0; e_back = 1'b0; e_vld = 1'b0;
      e_busy = (m_busy != 0);
      e_tmo = (c == m_tmo_at);
      n_run++; if (bus !== m_bus) begin n_fail++; $display("FAIL rnd_fields cyc=%0d got=%h want=%h", c, bus, m_bus); end
      n_run++; if (gb !== (m_gb != 0)) begin n_fail++; $display("FAIL rnd_grant_b cyc=%0d got=%b want=%0d", c, gb, m_gb); end
      if (m_busy == 0) begin
        if (a_vld || b_vld) begin
          pb = b_vld && (!a_vld || m_lastb == 0);
          e_aack = !pb; e_back = pb;
          m_bus = pb ? fb : fa;
          m_lastb = int'(pb); m_gb = int'(pb);
          m_busy = 1; m_ack = c; m_wend = -1; m_rec = 0;
        end
      end else begin
        ws = m_ack + 1 + CMD_LEN;
        if (c < ws) begin
          e_vld = 1'b1;
          if (done) m_rec = 1;
        end else if (m_wend < 0) begin
          if (done || m_rec != 0) m_wend = c;
          else if (c - ws == TMO_LEN - 1) begin m_wend = c; m_tmo_at = c + 1; end
        end
        if (m_wend >= 0 && c == m_wend + GAP_LEN) m_busy = 0;
      end
      n_run++; if (a_ack !== e_aack) begin n_fail++; $display("FAIL rnd_ack_a cyc=%0d got=%b want=%b", c, a_ack, e_aack); end
      n_run++; if (b_ack !== e_back) begin n_fail++; $display("FAIL rnd_ack_b cyc=%0d got=%b want=%b", c, b_ack, e_back); end
      n_run++; if (vld !== e_vld)    begin n_fail++; $display("FAIL rnd_cmd_vld cyc=%0d got=%b want=%b", c, vld, e_vld); end
      n_run++; if (busy !== e_busy)  begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", c, busy, e_busy); end
      n_run++; if (tmo !== e_tmo)    begin n_fail++; $display("FAIL rnd_tmo cyc=%0d got=%b want=%b", c, tmo, e_tmo); end
      adv();
      if (e_aack) a_vld = 1'b0;
      if (e_back) b_vld = 1'b0;
    end
    a_vld = 1'b0; b_vld = 1'b0; done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0; done = 1'b0;
    {a_dev, a_mod, a_addr, a_data} = 32'h0;
    {b_dev, b_mod, b_addr, b_data} = 32'h0;
    rst2 = 1'b1; a2_vld = 1'b0; b2_vld = 1'b0; done2 = 1'b0;
    {a2_dev, a2_mod, a2_addr, a2_data} = 32'hC1C2C3C4;
    {b2_dev, b2_mod, b2_addr, b2_data} = 32'hD1D2D3D4;
    adv();
    rst2 = 1'b0;
    test_reset();
    test_single_a();
    test_round_robin();
    test_done_in_issue();
    test_timeout();
    test_reset_mid();
    test_param();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
